// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared types and helpers for the execute-stage branch/jump resolver.
//   DATA_WIDTH        : width of pc, operands, immediates and targets
//   brjl_kind_e       : control-transfer kind (BR/JAL/JALR/RSV)
//   br_cond_e         : branch funct3 encodings
//   resolve_result_t  : one resolved branch/jump result
//   eval_cond()       : returns {illegal, taken} for a branch condition
package pipeline_pkg;

  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    KIND_BR   = 2'd0,
    KIND_JAL  = 2'd1,
    KIND_JALR = 2'd2,
    KIND_RSV  = 2'd3
  } brjl_kind_e;

  typedef enum logic [2:0] {
    COND_BEQ  = 3'b000,
    COND_BNE  = 3'b001,
    COND_BLT  = 3'b100,
    COND_BGE  = 3'b101,
    COND_BLTU = 3'b110,
    COND_BGEU = 3'b111
  } br_cond_e;

  typedef struct packed {
    logic                  taken;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] link;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  mispredict;
    logic                  misalign;
    logic                  illegal;
  } resolve_result_t;

  // funct3 010/011 have no branch meaning: flagged illegal and never taken.
  function automatic logic [1:0] eval_cond(input logic [2:0]            cond,
                                           input logic [DATA_WIDTH-1:0] a,
                                           input logic [DATA_WIDTH-1:0] b);
    logic taken;
    logic illegal;
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_BEQ:  taken = (a == b);
      COND_BNE:  taken = (a != b);
      COND_BLT:  taken = ($signed(a) <  $signed(b));
      COND_BGE:  taken = ($signed(a) >= $signed(b));
      COND_BLTU: taken = (a <  b);
      COND_BGEU: taken = (a >= b);
      default: begin
        taken   = 1'b0;
        illegal = 1'b1;
      end
    endcase
    return {illegal, taken};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack
// Circular return-address stack with saturating occupancy count.
//   clk, rst     : clock, synchronous active-high reset
//   push, pop    : push alone pushes, pop alone pops, both together replace the top
//   push_data    : address written on push/replace
//   top          : current top entry (0 when empty)
//   valid        : stack non-empty
// Pushing when full wraps the pointer and overwrites the oldest entry.
module ras_stack #(
  parameter int DATA_WIDTH = 64,
  parameter int RAS_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top,
  output logic                  valid
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_empty;
  logic                  w_full;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_wr_en;
  logic [PTR_W-1:0]      w_wr_idx;

  assign w_empty = (r_count == {CNT_W{1'b0}});
  assign w_full  = (r_count == CNT_W'(RAS_DEPTH));

  // Next pointer/count and write slot for push, pop or replace.
  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_ptr;
    if (push && (!pop || w_empty)) begin
      // Plain push; a replace on an empty stack degenerates to a push.
      w_ptr_nxt   = r_ptr + PTR_W'(1);
      w_wr_idx    = r_ptr + PTR_W'(1);
      w_wr_en     = 1'b1;
      w_count_nxt = w_full ? r_count : r_count + CNT_W'(1);
    end else if (push) begin
      // Pop-then-push collapses into overwriting the top in place.
      w_wr_en  = 1'b1;
      w_wr_idx = r_ptr;
    end else if (pop && !w_empty) begin
      w_ptr_nxt   = r_ptr - PTR_W'(1);
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_ptr_nxt   = r_ptr;
      w_count_nxt = r_count;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Entry storage; contents are don't-care while the count excludes them.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  assign top   = w_empty ? {DATA_WIDTH{1'b0}} : r_mem[r_ptr];
  assign valid = !w_empty;

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-stage branch/jump resolver with one registered output stage.
//   clk, rst, flush          : clock, sync active-high reset, pipeline flush
//   in_valid/in_ready        : request handshake
//   in_pc, in_kind, in_cond  : instruction pc, kind (BR/JAL/JALR/RSV), funct3
//   in_rs1, in_rs2, in_imme  : operands and sign-extended immediate
//   in_rd_link, in_rs1_link  : rd / rs1 is a link register (x1/x5)
//   in_pred_taken/_target    : frontend prediction
//   out_valid/out_ready      : result handshake
//   out_*                    : resolved direction, targets, mispredict/misalign/illegal
//   ras_top, ras_valid       : return-address stack top and non-empty flag
// DATA_WIDTH must match pipeline_pkg::DATA_WIDTH (the result struct uses it).
module branch_resolve_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int RAS_DEPTH  = 8,
  parameter int INST_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [1:0]            in_kind,
  input  logic [2:0]            in_cond,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imme,
  input  logic                  in_rd_link,
  input  logic                  in_rs1_link,
  input  logic                  in_pred_taken,
  input  logic [DATA_WIDTH-1:0] in_pred_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_taken,
  output logic [DATA_WIDTH-1:0] out_target,
  output logic [DATA_WIDTH-1:0] out_link,
  output logic [DATA_WIDTH-1:0] out_redirect_pc,
  output logic                  out_mispredict,
  output logic                  out_misalign,
  output logic                  out_illegal,
  output logic [DATA_WIDTH-1:0] ras_top,
  output logic                  ras_valid
);

  import pipeline_pkg::*;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [1:0]            w_cond_eval;
  logic [DATA_WIDTH-1:0] w_link;
  logic [DATA_WIDTH-1:0] w_pc_sum;
  logic [DATA_WIDTH-1:0] w_rs1_sum;
  logic                  w_is_jump;
  logic                  w_ras_push;
  logic                  w_ras_pop;
  resolve_result_t       w_res;
  resolve_result_t       r_res;
  logic                  r_out_valid;

  assign w_in_ready  = !flush && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_cond_eval = eval_cond(in_cond, in_rs1, in_rs2);
  assign w_link      = in_pc + DATA_WIDTH'(INST_BYTES);
  assign w_pc_sum    = in_pc + in_imme;
  assign w_rs1_sum   = in_rs1 + in_imme;

  // Combinational resolution of direction, target and prediction check.
  always_comb begin
    w_res      = '{default: 1'b0};
    w_res.link = w_link;
    case (in_kind)
      KIND_BR: begin
        w_res.taken   = w_cond_eval[0];
        w_res.illegal = w_cond_eval[1];
        w_res.target  = w_pc_sum;
      end
      KIND_JAL: begin
        w_res.taken  = 1'b1;
        w_res.target = w_pc_sum;
      end
      KIND_JALR: begin
        w_res.taken  = 1'b1;
        w_res.target = w_rs1_sum & ~{{(DATA_WIDTH-1){1'b0}}, 1'b1};
      end
      default: begin
        w_res.taken   = 1'b0;
        w_res.illegal = 1'b1;
        w_res.target  = {DATA_WIDTH{1'b0}};
      end
    endcase
    w_res.redirect_pc = w_res.taken ? w_res.target : w_link;
    w_res.misalign    = w_res.taken && w_res.target[1];
    if (w_res.illegal) begin
      w_res.mispredict = 1'b0;
    end else begin
      w_res.mispredict = (w_res.taken != in_pred_taken) ||
                         (w_res.taken && (w_res.target != in_pred_target));
    end
  end

  // Link-register convention: JALR with link rs1 pops; link rd pushes (both = replace).
  assign w_is_jump  = (in_kind == KIND_JAL) || (in_kind == KIND_JALR);
  assign w_ras_push = w_accept && w_is_jump && in_rd_link;
  assign w_ras_pop  = w_accept && (in_kind == KIND_JALR) && in_rs1_link;

  // Output register: flush kills, accept loads, consumer handshake drains, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_res       <= '{default: 1'b0};
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_res       <= w_res;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  ras_stack #(
    .DATA_WIDTH(DATA_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (w_ras_push),
    .pop      (w_ras_pop),
    .push_data(w_link),
    .top      (ras_top),
    .valid    (ras_valid)
  );

  assign in_ready        = w_in_ready;
  assign out_valid       = r_out_valid;
  assign out_taken       = r_res.taken;
  assign out_target      = r_res.target;
  assign out_link        = r_res.link;
  assign out_redirect_pc = r_res.redirect_pc;
  assign out_mispredict  = r_res.mispredict;
  assign out_misalign    = r_res.misalign;
  assign out_illegal     = r_res.illegal;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: issued requests push hand-computed
// results into a queue; a monitor pops and compares on every output handshake.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [63:0] in_pc, in_rs1, in_rs2, in_imme, in_pred_target;
  logic [1:0]  in_kind;
  logic [2:0]  in_cond;
  logic        in_rd_link, in_rs1_link, in_pred_taken;
  logic        out_valid, out_ready, out_taken, out_mispredict, out_misalign, out_illegal;
  logic [63:0] out_target, out_link, out_redirect_pc, ras_top;
  logic        ras_valid;

  typedef struct {
    logic        taken;
    logic [63:0] target;
    logic [63:0] link;
    logic [63:0] redirect;
    logic        mis;
    logic        misal;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_WIDTH(64), .RAS_DEPTH(8), .INST_BYTES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_kind(in_kind), .in_cond(in_cond),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imme(in_imme),
    .in_rd_link(in_rd_link), .in_rs1_link(in_rs1_link),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
    .out_redirect_pc(out_redirect_pc), .out_mispredict(out_mispredict),
    .out_misalign(out_misalign), .out_illegal(out_illegal),
    .ras_top(ras_top), .ras_valid(ras_valid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic tk, input logic [63:0] tgt, input logic [63:0] lnk,
                              input logic [63:0] rd, input logic mis, input logic mal,
                              input logic ill);
    exp_t e;
    e.taken = tk; e.target = tgt; e.link = lnk; e.redirect = rd;
    e.mis = mis; e.misal = mal; e.ill = ill;
    return e;
  endfunction

  // Monitor: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: actual target=%h required no output", out_target);
      end else begin
        mon_e = sb_q.pop_front();
        check("taken",    {63'd0, out_taken},      {63'd0, mon_e.taken});
        check("target",   out_target,              mon_e.target);
        check("link",     out_link,                mon_e.link);
        check("redirect", out_redirect_pc,         mon_e.redirect);
        check("mispred",  {63'd0, out_mispredict}, {63'd0, mon_e.mis});
        check("misalign", {63'd0, out_misalign},   {63'd0, mon_e.misal});
        check("illegal",  {63'd0, out_illegal},    {63'd0, mon_e.ill});
      end
    end
  end

  task automatic set_req(input logic [1:0] kind, input logic [2:0] cond, input logic [63:0] pc,
                         input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                         input logic rdl, input logic r1l, input logic pt, input logic [63:0] ptgt);
    in_kind = kind; in_cond = cond; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imme = imm;
    in_rd_link = rdl; in_rs1_link = r1l; in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  // Drive one request until accepted (bounded), recording its expected result.
  task automatic issue(input logic [1:0] kind, input logic [2:0] cond, input logic [63:0] pc,
                       input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                       input logic rdl, input logic r1l, input logic pt, input logic [63:0] ptgt,
                       input exp_t e);
    int waited;
    set_req(kind, cond, pc, rs1, rs2, imm, rdl, r1l, pt, ptgt);
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: actual in_ready=0 required 1 for pc=%h", pc);
    end else begin
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] pc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_req(2'd0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ras_valid", {63'd0, ras_valid}, 64'd0);
    check("rst_ras_top",   ras_top,            64'd0);
    check("rst_target",    out_target,         64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);

    // Directed resolution vectors.
    issue(2'd0, 3'b000, 64'h1000, 64'd5, 64'd5, 64'h20, 1'b0, 1'b0, 1'b0, 64'd0,
          mk(1'b1, 64'h1020, 64'h1004, 64'h1020, 1'b1, 1'b0, 1'b0));
    issue(2'd0, 3'b100, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 1'b0, 1'b0, 1'b1, 64'h1040,
          mk(1'b1, 64'h1040, 64'h1004, 64'h1040, 1'b0, 1'b0, 1'b0));
    issue(2'd0, 3'b110, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 1'b0, 1'b0, 1'b1, 64'h1040,
          mk(1'b0, 64'h1040, 64'h1004, 64'h1004, 1'b1, 1'b0, 1'b0));
    issue(2'd0, 3'b010, 64'h1000, 64'd0, 64'd0, 64'h40, 1'b0, 1'b0, 1'b1, 64'h1040,
          mk(1'b0, 64'h1040, 64'h1004, 64'h1004, 1'b0, 1'b0, 1'b1));
    issue(2'd2, 3'b000, 64'h3000, 64'h2003, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h2002,
          mk(1'b1, 64'h2002, 64'h3004, 64'h2002, 1'b0, 1'b1, 1'b0));
    issue(2'd0, 3'b001, 64'h2000, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0, 64'd0,
          mk(1'b0, 64'h1FF8, 64'h2004, 64'h2004, 1'b0, 1'b0, 1'b0));
    issue(2'd0, 3'b101, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFA, 64'h100,
          1'b0, 1'b0, 1'b1, 64'h4104,
          mk(1'b1, 64'h4100, 64'h4004, 64'h4100, 1'b1, 1'b0, 1'b0));
    issue(2'd0, 3'b111, 64'h5000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, 1'b0, 64'd0,
          mk(1'b0, 64'h5010, 64'h5004, 64'h5004, 1'b0, 1'b0, 1'b0));
    issue(2'd3, 3'b000, 64'h6000, 64'd0, 64'd0, 64'h8, 1'b0, 1'b0, 1'b1, 64'h6008,
          mk(1'b0, 64'd0, 64'h6004, 64'h6004, 1'b0, 1'b0, 1'b1));
    issue(2'd1, 3'b000, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0, 64'h20, 1'b0, 1'b0, 1'b1, 64'h10,
          mk(1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFF4, 64'h10, 1'b0, 1'b0, 1'b0));
    issue(2'd1, 3'b000, 64'h100, 64'd0, 64'd0, 64'h2, 1'b0, 1'b0, 1'b1, 64'h102,
          mk(1'b1, 64'h102, 64'h104, 64'h102, 1'b0, 1'b1, 1'b0));
    check("no_link_ras_empty", {63'd0, ras_valid}, 64'd0);

    // RAS overflow: nine pushes into eight entries.
    for (int i = 1; i <= 9; i++) begin
      pc = 64'(i) * 64'h100;
      issue(2'd1, 3'b000, pc, 64'd0, 64'd0, 64'h40, 1'b1, 1'b0, 1'b1, pc + 64'h40,
            mk(1'b1, pc + 64'h40, pc + 64'h4, pc + 64'h40, 1'b0, 1'b0, 1'b0));
    end
    check("ras_full_top",   ras_top,            64'h904);
    check("ras_full_valid", {63'd0, ras_valid}, 64'd1);

    // Eight pops drain exactly the eight surviving entries.
    for (int k = 1; k <= 8; k++) begin
      check("ras_pop_top", ras_top, 64'(10 - k) * 64'h100 + 64'h4);
      issue(2'd2, 3'b000, 64'h9000, 64'h8000, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 64'h8000,
            mk(1'b1, 64'h8000, 64'h9004, 64'h8000, 1'b0, 1'b0, 1'b0));
    end
    check("ras_drained_valid", {63'd0, ras_valid}, 64'd0);
    check("ras_drained_top",   ras_top,            64'd0);
    issue(2'd2, 3'b000, 64'h9000, 64'h8000, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 64'h8000,
          mk(1'b1, 64'h8000, 64'h9004, 64'h8000, 1'b0, 1'b0, 1'b0));
    check("ras_underflow_valid", {63'd0, ras_valid}, 64'd0);

    // Replace: on a one-entry stack, then on an empty stack.
    issue(2'd1, 3'b000, 64'hA00, 64'd0, 64'd0, 64'h40, 1'b1, 1'b0, 1'b1, 64'hA40,
          mk(1'b1, 64'hA40, 64'hA04, 64'hA40, 1'b0, 1'b0, 1'b0));
    check("ras_push_top", ras_top, 64'hA04);
    issue(2'd2, 3'b000, 64'hB00, 64'h8000, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1, 64'h8000,
          mk(1'b1, 64'h8000, 64'hB04, 64'h8000, 1'b0, 1'b0, 1'b0));
    check("ras_replace_top", ras_top, 64'hB04);
    issue(2'd2, 3'b000, 64'h9000, 64'h8000, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 64'h8000,
          mk(1'b1, 64'h8000, 64'h9004, 64'h8000, 1'b0, 1'b0, 1'b0));
    check("ras_replace_count", {63'd0, ras_valid}, 64'd0);
    issue(2'd2, 3'b000, 64'hC00, 64'h8000, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1, 64'h8000,
          mk(1'b1, 64'h8000, 64'hC04, 64'h8000, 1'b0, 1'b0, 1'b0));
    check("ras_replace_empty_top", ras_top, 64'hC04);
    issue(2'd2, 3'b000, 64'h9000, 64'h8000, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 64'h8000,
          mk(1'b1, 64'h8000, 64'h9004, 64'h8000, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;

    // Backpressure then flush; this result is killed, so it is not queued.
    out_ready = 1'b0;
    set_req(2'd0, 3'b000, 64'h7000, 64'd1, 64'd2, 64'h80, 1'b0, 1'b0, 1'b0, 64'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    set_req(2'd1, 3'b000, 64'h7100, 64'd0, 64'd0, 64'h40, 1'b1, 1'b0, 1'b1, 64'h7140);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready",  {63'd0, in_ready},  64'd0);
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check("stall_target",    out_target,         64'h7080);
      check("stall_redirect",  out_redirect_pc,    64'h7004);
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_ras_valid", {63'd0, ras_valid}, 64'd0);
    check("flush_ras_top",   ras_top,            64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("flush_no_accept", {63'd0, out_valid}, 64'd0);

    // Reset mid-stream after three pushes.
    for (int i = 1; i <= 3; i++) begin
      pc = 64'h1000 + 64'(i) * 64'h100;
      issue(2'd1, 3'b000, pc, 64'd0, 64'd0, 64'h40, 1'b1, 1'b0, 1'b1, pc + 64'h40,
            mk(1'b1, pc + 64'h40, pc + 64'h4, pc + 64'h40, 1'b0, 1'b0, 1'b0));
    end
    check("pre_rst_ras_top", ras_top, 64'h1304);
    set_req(2'd1, 3'b000, 64'h1400, 64'd0, 64'd0, 64'h40, 1'b1, 1'b0, 1'b1, 64'h1440);
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", {63'd0, out_valid},      64'd0);
    check("mid_rst_ras_valid", {63'd0, ras_valid},      64'd0);
    check("mid_rst_ras_top",   ras_top,                 64'd0);
    check("mid_rst_taken",     {63'd0, out_taken},      64'd0);
    check("mid_rst_target",    out_target,              64'd0);
    check("mid_rst_link",      out_link,                64'd0);
    check("mid_rst_redirect",  out_redirect_pc,         64'd0);
    check("mid_rst_flags",     {61'd0, out_mispredict, out_misalign, out_illegal}, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch/jump resolver; generalises the combinational target calculator.
- Evaluates RV64I branch conditions, computes taken/not-taken targets and detects mispredicts against the frontend's prediction.
- Maintains a parametrised return-address stack (RAS) for frontend prediction.
- Registered output stage with valid/ready handshake; sits between decode/regread and commit/redirect logic.

Parameters:
- DATA_WIDTH, 64, width of pc, operands, immediate and targets.
- RAS_DEPTH, 8, RAS entries; must be a power of two and at least 2.
- INST_BYTES, 4, fall-through increment (pc + INST_BYTES).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; kills the output register and blocks acceptance this cycle
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept
- in_pc  in  DATA_WIDTH  instruction pc
- in_kind  in  2  0=BR, 1=JAL, 2=JALR, 3=reserved
- in_cond  in  3  branch funct3
- in_rs1, in_rs2, in_imme  in  DATA_WIDTH  operands; imme is sign-extended
- in_rd_link, in_rs1_link  in  1  rd or rs1 is x1/x5
- in_pred_taken  in  1  frontend prediction
- in_pred_target  in  DATA_WIDTH  frontend predicted target
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_taken  out  1  resolved direction
- out_target  out  DATA_WIDTH  resolved taken target
- out_link  out  DATA_WIDTH  pc + INST_BYTES (rd writeback for JAL/JALR)
- out_redirect_pc  out  DATA_WIDTH  out_taken ? out_target : out_link
- out_mispredict  out  1  prediction wrong
- out_misalign  out  1  taken and out_target[1] set
- out_illegal  out  1  bad kind or cond
- ras_top  out  DATA_WIDTH  current RAS top
- ras_valid  out  1  RAS non-empty

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - All out_* registers cleared to 0.
  - RAS count 0 and pointer 0, so ras_valid = 0 and ras_top = 0.
- in_ready = !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
- Latency: exactly 1 cycle from accept to out_valid.
- Output register:
  - Holds stable while out_valid && !out_ready.
  - On flush: out_valid becomes 0 next cycle, regardless of out_ready.
- Condition evaluation:
  - 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - 010 and 011: out_illegal = 1, taken = 0.
- Targets:
  - BR and JAL: target = pc + imme.
  - JALR: target = (rs1 + imme) & ~1.
  - JAL and JALR: always taken.
  - kind 3: out_illegal = 1, taken = 0, target = 0.
  - All arithmetic is modulo 2^DATA_WIDTH; wrap-around is silent.
- out_mispredict = (taken != pred_taken) || (taken && target != pred_target).
  - Forced to 0 when out_illegal.
- RAS updates happen only on accept and only for JAL/JALR that are not illegal:
  - rd_link && !rs1_link: push link.
  - !rd_link && rs1_link: pop.
  - rd_link && rs1_link: pop then push, i.e. the top entry is replaced by link; count unchanged unless empty, where it becomes 1.
  - JAL ignores rs1_link (push only).
- RAS boundaries:
  - Push when full: pointer wraps and overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no state change.
- RAS updates are visible on ras_top the cycle after accept. Flush does not roll back the RAS.
- Simultaneous flush and in_valid: the request is not accepted and RAS is untouched.

Decomposition:
- pipeline_pkg gains:
  - brjl_kind_e enum (BR/JAL/JALR/RSV).
  - br_cond_e funct3 constants.
  - resolve_result_t struct (taken, target, link, redirect_pc, mispredict, misalign, illegal).
- DATA_WIDTH stays in pipeline_pkg.
- One sub-module: ras_stack. Parameters DATA_WIDTH and RAS_DEPTH; ports push, pop, push_data, top, valid; circular buffer with saturating count.

Test Plan:
- BEQ, pc=0x1000, rs1=rs2=5, imme=0x20, pred_taken=0 -> next cycle out_taken=1, target=0x1020, mispredict=1, redirect=0x1020.
- BLT with rs1=-1, rs2=1 -> taken=1. BLTU with the same operands -> taken=0. cond=010 -> illegal=1, mispredict=0.
- JALR, rs1=0x2003, imme=0, pred_target=0x2002 -> target=0x2002, mispredict=0, misalign=1.
- Nine JAL rd_link pushes with pc=0x100·i (i=1..9), RAS_DEPTH=8:
  - ras_top=0x904 and count stays 8.
  - Eight pops empty the stack, the last returning 0x204; a ninth pop leaves ras_valid=0.
- out_ready held 0 for 3 cycles with a second request pending: in_ready=0 and outputs stable. Then assert flush: out_valid=0 next cycle, pending request not accepted, RAS unchanged.
- rst asserted mid-stream after 3 pushes -> next cycle out_valid=0, ras_valid=0, all outputs 0.
